// File: rtl/legv8_multicycle_core.sv
// Multi-cycle LEGv8 core: a single FSM walks each instruction through
// fetch, decode, execute, memory and write-back so that instruction and
// data memories can be slow req/ready ports with any number of wait states.
// Contains its own 32-entry register file (X31 reads as zero) and ALU.
// Unsupported encodings park the core in HALT until reset.
module legv8_multicycle_core #(
    parameter int                DATA_W   = 64,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              retire,
    output logic              halted,
    output logic [DATA_W-1:0] pc_out
);

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [5:0]  OP_B    = 6'h05;

    typedef enum logic [2:0] {
        START,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } stateT;

    stateT state;
    stateT nextState;

    logic [DATA_W-1:0] pc;
    logic [31:0]       ir;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] aluResult;
    logic [DATA_W-1:0] regs [32];

    logic isAdd, isSub, isAnd, isOrr;
    logic isLdur, isStur, isCbz, isB;
    logic isRType, isMem, isBranch, isSupported;

    logic [4:0] rn;
    logic [4:0] rm;
    logic [4:0] rt;
    logic [4:0] rbSel;

    logic [DATA_W-1:0] readA;
    logic [DATA_W-1:0] readB;
    logic [DATA_W-1:0] memOffset;
    logic [DATA_W-1:0] cbzOffset;
    logic [DATA_W-1:0] bOffset;
    logic [DATA_W-1:0] pcPlus4;

    // The IR is held from FETCH to the end of the instruction, so the
    // decode below is valid in every state after the fetch completes.
    assign isAdd  = (ir[31:21] == OP_ADD);
    assign isSub  = (ir[31:21] == OP_SUB);
    assign isAnd  = (ir[31:21] == OP_AND);
    assign isOrr  = (ir[31:21] == OP_ORR);
    assign isLdur = (ir[31:21] == OP_LDUR);
    assign isStur = (ir[31:21] == OP_STUR);
    assign isCbz  = (ir[31:24] == OP_CBZ);
    assign isB    = (ir[31:26] == OP_B);

    assign isRType     = isAdd | isSub | isAnd | isOrr;
    assign isMem       = isLdur | isStur;
    assign isBranch    = isCbz | isB;
    assign isSupported = isRType | isMem | isBranch;

    assign rn    = ir[9:5];
    assign rm    = ir[20:16];
    assign rt    = ir[4:0];
    assign rbSel = isRType ? rm : rt;

    assign readA = (rn == 5'd31) ? '0 : regs[rn];
    assign readB = (rbSel == 5'd31) ? '0 : regs[rbSel];

    assign memOffset = {{(DATA_W-9){ir[20]}}, ir[20:12]};
    assign cbzOffset = {{(DATA_W-21){ir[23]}}, ir[23:5], 2'b00};
    assign bOffset   = {{(DATA_W-28){ir[25]}}, ir[25:0], 2'b00};
    assign pcPlus4   = pc + DATA_W'(4);

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = aluOut;
    assign dmem_wdata = opB;

    // State register; reset drops straight into START so all requests
    // fall asynchronously with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= START;
        end else begin
            state <= nextState;
        end
    end

    // Next-state sequencing and the handshake/status outputs, all decoded
    // from the current state so requests stay constant until acknowledged.
    always_comb begin
        nextState = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;
        halted    = 1'b0;
        case (state)
            START: begin
                nextState = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    nextState = DECODE;
                end
            end
            DECODE: begin
                nextState = isSupported ? EXEC : HALT;
            end
            EXEC: begin
                if (isRType) begin
                    nextState = WB;
                end else if (isMem) begin
                    nextState = MEM;
                end else begin
                    retire    = 1'b1;
                    nextState = FETCH;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                dmem_we  = isStur;
                if (dmem_ready) begin
                    if (isLdur) begin
                        nextState = WB;
                    end else begin
                        retire    = 1'b1;
                        nextState = FETCH;
                    end
                end
            end
            WB: begin
                retire    = 1'b1;
                nextState = FETCH;
            end
            HALT: begin
                halted = 1'b1;
            end
            default: begin
                nextState = HALT;
            end
        endcase
    end

    // ALU: R-type operations, otherwise the load/store effective address.
    always_comb begin
        aluResult = opA + memOffset;
        if (isAdd) begin
            aluResult = opA + opB;
        end else if (isSub) begin
            aluResult = opA - opB;
        end else if (isAnd) begin
            aluResult = opA & opB;
        end else if (isOrr) begin
            aluResult = opA | opB;
        end
    end

    // Datapath registers: IR capture, operand latches, ALU/address result,
    // load data, and every PC update (sequential, branch, post-store, WB).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            opA    <= '0;
            opB    <= '0;
            aluOut <= '0;
            mdr    <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        ir <= imem_rdata;
                    end
                end
                DECODE: begin
                    opA <= readA;
                    opB <= readB;
                end
                EXEC: begin
                    aluOut <= aluResult;
                    if (isCbz) begin
                        pc <= (opB == '0) ? pc + cbzOffset : pcPlus4;
                    end else if (isB) begin
                        pc <= pc + bOffset;
                    end
                end
                MEM: begin
                    if (dmem_ready) begin
                        if (isLdur) begin
                            mdr <= dmem_rdata;
                        end else begin
                            pc <= pcPlus4;
                        end
                    end
                end
                WB: begin
                    pc <= pcPlus4;
                end
                default: begin
                end
            endcase
        end
    end

    // Register file write port; only WB writes, and X31 is never written so
    // the zero register needs no special storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (state == WB && rt != 5'd31) begin
            regs[rt] <= isLdur ? mdr : aluOut;
        end
    end

endmodule

// File: tb/tb_legv8_multicycle_core.sv
// Directed testbench for legv8_multicycle_core: bench-side instruction and
// data memories with programmable wait states, one task per scenario.
module tb_legv8_multicycle_core;

    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ready;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ready;
    logic              retire;
    logic              halted;
    logic [DATA_W-1:0] pc_out;

    logic [31:0] imem [256];
    logic [63:0] dmem [64];
    int imemWait = 0;
    int dmemWait = 0;
    int imemCnt  = 0;
    int dmemCnt  = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } storeT;
    storeT storeQ[$];

    int          retireCycles[$];
    logic [63:0] fetchAddrs[$];
    logic [63:0] pcAfterRetire[$];
    int          stableErrs;
    int          imemReqCycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    legv8_multicycle_core #(.DATA_W(DATA_W), .RESET_PC(64'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .retire     (retire),
        .halted     (halted),
        .pc_out     (pc_out)
    );

    // Instruction memory responder: raises ready after imemWait stalled cycles.
    always @(posedge clk) begin
        #1;
        if (imem_req) begin
            if (imemCnt >= imemWait) begin
                imem_ready = 1'b1;
                imem_rdata = imem[imem_addr[9:2]];
            end else begin
                imem_ready = 1'b0;
                imemCnt++;
            end
        end else begin
            imem_ready = 1'b0;
            imemCnt    = 0;
        end
    end

    // Data memory responder: raises ready after dmemWait stalled cycles.
    always @(posedge clk) begin
        #1;
        if (dmem_req) begin
            if (dmemCnt >= dmemWait) begin
                dmem_ready = 1'b1;
                dmem_rdata = dmem[dmem_addr[8:3]];
            end else begin
                dmem_ready = 1'b0;
                dmemCnt++;
            end
        end else begin
            dmem_ready = 1'b0;
            dmemCnt    = 0;
        end
    end

    // Store capture: a store is committed on the edge following this sample.
    always @(negedge clk) begin
        if (!reset && dmem_req && dmem_ready && dmem_we) begin
            storeQ.push_back('{dmem_addr, dmem_wdata});
            dmem[dmem_addr[8:3]] = dmem_wdata;
        end
    end

    function automatic logic [31:0] encR(input logic [10:0] op, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    function automatic logic [31:0] encD(input logic [10:0] op, input logic [4:0] rt,
                                         input logic [4:0] rn, input logic [8:0] imm);
        return {op, imm, 2'b00, rn, rt};
    endfunction

    function automatic logic [31:0] encCbz(input logic [4:0] rt, input logic [18:0] imm);
        return {8'hB4, imm, rt};
    endfunction

    function automatic logic [31:0] encB(input logic [25:0] imm);
        return {6'h05, imm};
    endfunction

    task automatic fillMem(input logic [31:0] word);
        for (int i = 0; i < 256; i++) imem[i] = word;
        for (int i = 0; i < 64; i++) dmem[i] = 64'h0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        storeQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Runs nCycles cycles (cycle 1 = first cycle after START) and records
    // retire cycles, fetch addresses, PC after each retire and handshake stability.
    task automatic applyStimulus(input int nCycles);
        logic        pIReq = 0, pIRdy = 0, pDReq = 0, pDRdy = 0, pDWe = 0, retiredLast = 0;
        logic [63:0] pIAddr = 0, pDAddr = 0, pDWdata = 0;
        retireCycles.delete();
        fetchAddrs.delete();
        pcAfterRetire.delete();
        stableErrs    = 0;
        imemReqCycles = 0;
        for (int k = 1; k <= nCycles; k++) begin
            @(negedge clk);
            if (retiredLast) pcAfterRetire.push_back(pc_out);
            retiredLast = retire;
            if (retire) retireCycles.push_back(k);
            if (imem_req) imemReqCycles++;
            if (imem_req && imem_ready) fetchAddrs.push_back(imem_addr);
            if (imem_req && imem_addr !== pc_out) stableErrs++;
            if (pIReq && !pIRdy && (!imem_req || imem_addr !== pIAddr)) stableErrs++;
            if (pDReq && !pDRdy && (!dmem_req || dmem_addr !== pDAddr ||
                dmem_we !== pDWe || dmem_wdata !== pDWdata)) stableErrs++;
            pIReq = imem_req;  pIRdy = imem_ready;  pIAddr = imem_addr;
            pDReq = dmem_req;  pDRdy = dmem_ready;  pDAddr = dmem_addr;
            pDWe  = dmem_we;   pDWdata = dmem_wdata;
        end
    endtask

    task automatic test_load_add_store();
        int expRet[4] = '{5, 10, 14, 18};
        int got;
        fillMem(encB(26'd0));
        imem[0] = encD(11'h7C2, 5'd1, 5'd31, 9'd0);
        imem[1] = encD(11'h7C2, 5'd2, 5'd31, 9'd8);
        imem[2] = encR(11'h458, 5'd3, 5'd1, 5'd2);
        imem[3] = encD(11'h7C0, 5'd3, 5'd31, 9'd16);
        dmem[0] = 64'd5;
        dmem[1] = 64'd7;
        imemWait = 0;
        dmemWait = 0;
        doReset();
        applyStimulus(24);
        for (int i = 0; i < 4; i++) begin
            got = (i < retireCycles.size()) ? retireCycles[i] : -1;
            total++;
            if (got !== expRet[i]) begin
                bad++;
                $display("[TB] FAIL las_retire_cycle[%0d] got=%0d want=%0d", i, got, expRet[i]);
            end
        end
        total++;
        if (storeQ.size() != 1) begin
            bad++;
            $display("[TB] FAIL las_store_count got=%0d want=1", storeQ.size());
        end else begin
            total++;
            if (storeQ[0].addr !== 64'd16 || storeQ[0].data !== 64'd12) begin
                bad++;
                $display("[TB] FAIL las_store got=addr %0h data %0h want=addr 10 data c",
                         storeQ[0].addr, storeQ[0].data);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        total++;
        if ({imem_req, dmem_req, dmem_we, retire, halted} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_controls got=%05b want=00000",
                     {imem_req, dmem_req, dmem_we, retire, halted});
        end
        total++;
        if (pc_out !== 64'h0 || imem_addr !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_pc got=pc %0h addr %0h want=0", pc_out, imem_addr);
        end
        total++;
        if (dmem_addr !== 64'h0 || dmem_wdata !== 64'h0) begin
            bad++;
            $display("[TB] FAIL reset_dmem_bus got=addr %0h wdata %0h want=0", dmem_addr, dmem_wdata);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL start_no_req got=%0b want=0", imem_req);
        end
        @(negedge clk);
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            bad++;
            $display("[TB] FAIL first_fetch got=req %0b addr %0h want=req 1 addr 0", imem_req, imem_addr);
        end
    endtask

    task automatic test_alu_ops();
        logic [63:0] expAddr[4] = '{64'd24, 64'd32, 64'd40, 64'd48};
        logic [63:0] expData[4] = '{64'd2, 64'd8, 64'd14, 64'd0};
        fillMem(encB(26'd0));
        imem[0]  = encD(11'h7C2, 5'd1, 5'd31, 9'd0);
        imem[1]  = encD(11'h7C2, 5'd2, 5'd31, 9'd8);
        imem[2]  = encR(11'h658, 5'd4, 5'd1, 5'd2);
        imem[3]  = encR(11'h450, 5'd5, 5'd1, 5'd2);
        imem[4]  = encR(11'h550, 5'd6, 5'd1, 5'd2);
        imem[5]  = encD(11'h7C0, 5'd4, 5'd31, 9'd24);
        imem[6]  = encD(11'h7C0, 5'd5, 5'd31, 9'd32);
        imem[7]  = encD(11'h7C0, 5'd6, 5'd31, 9'd40);
        imem[8]  = encR(11'h458, 5'd31, 5'd1, 5'd2);
        imem[9]  = encD(11'h7C0, 5'd31, 5'd31, 9'd48);
        dmem[0] = 64'd12;
        dmem[1] = 64'd10;
        dmem[6] = 64'hDEAD;
        doReset();
        applyStimulus(60);
        total++;
        if (storeQ.size() != 4) begin
            bad++;
            $display("[TB] FAIL alu_store_count got=%0d want=4", storeQ.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                total++;
                if (storeQ[i].addr !== expAddr[i] || storeQ[i].data !== expData[i]) begin
                    bad++;
                    $display("[TB] FAIL alu_store[%0d] got=addr %0h data %0h want=addr %0h data %0h",
                             i, storeQ[i].addr, storeQ[i].data, expAddr[i], expData[i]);
                end
            end
        end
    endtask

    task automatic test_branches();
        int          expRet[6]   = '{5, 8, 11, 14, 17, 20};
        logic [63:0] expFetch[7] = '{64'h0, 64'h4, 64'h40, 64'h4C, 64'h50, 64'h48, 64'h48};
        logic [63:0] expPc[6]    = '{64'h4, 64'h40, 64'h4C, 64'h50, 64'h48, 64'h48};
        int          gotI;
        logic [63:0] gotA;
        fillMem(encB(26'd0));
        imem[0]  = encD(11'h7C2, 5'd1, 5'd31, 9'd0);
        imem[1]  = encB(26'd15);
        imem[16] = encCbz(5'd0, 19'd3);
        imem[19] = encCbz(5'd1, 19'd3);
        imem[20] = encB(26'h3FFFFFE);
        imem[18] = encB(26'd0);
        dmem[0] = 64'd12;
        doReset();
        applyStimulus(24);
        for (int i = 0; i < 6; i++) begin
            gotI = (i < retireCycles.size()) ? retireCycles[i] : -1;
            total++;
            if (gotI !== expRet[i]) begin
                bad++;
                $display("[TB] FAIL br_retire_cycle[%0d] got=%0d want=%0d", i, gotI, expRet[i]);
            end
        end
        for (int i = 0; i < 7; i++) begin
            gotA = (i < fetchAddrs.size()) ? fetchAddrs[i] : 64'hFFFF_FFFF;
            total++;
            if (gotA !== expFetch[i]) begin
                bad++;
                $display("[TB] FAIL br_fetch_addr[%0d] got=%0h want=%0h", i, gotA, expFetch[i]);
            end
        end
        for (int i = 0; i < 6; i++) begin
            gotA = (i < pcAfterRetire.size()) ? pcAfterRetire[i] : 64'hFFFF_FFFF;
            total++;
            if (gotA !== expPc[i]) begin
                bad++;
                $display("[TB] FAIL br_pc_after_retire[%0d] got=%0h want=%0h", i, gotA, expPc[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        int got;
        fillMem(encB(26'd0));
        imem[0] = encD(11'h7C2, 5'd1, 5'd31, 9'd8);
        imem[1] = encD(11'h7C0, 5'd1, 5'd31, 9'd56);
        dmem[1] = 64'h1234_5678_9ABC_DEF0;
        imemWait = 3;
        dmemWait = 2;
        doReset();
        applyStimulus(30);
        got = (retireCycles.size() > 0) ? retireCycles[0] : -1;
        total++;
        if (got !== 10) begin
            bad++;
            $display("[TB] FAIL wait_ldur_latency got=%0d want=10", got);
        end
        got = (retireCycles.size() > 1) ? retireCycles[1] : -1;
        total++;
        if (got !== 19) begin
            bad++;
            $display("[TB] FAIL wait_stur_retire got=%0d want=19", got);
        end
        total++;
        if (stableErrs !== 0) begin
            bad++;
            $display("[TB] FAIL wait_req_stable got=%0d want=0", stableErrs);
        end
        total++;
        if (storeQ.size() != 1) begin
            bad++;
            $display("[TB] FAIL wait_store_count got=%0d want=1", storeQ.size());
        end else begin
            total++;
            if (storeQ[0].addr !== 64'd56 || storeQ[0].data !== 64'h1234_5678_9ABC_DEF0) begin
                bad++;
                $display("[TB] FAIL wait_store got=addr %0h data %0h want=addr 38 data 123456789abcdef0",
                         storeQ[0].addr, storeQ[0].data);
            end
        end
        imemWait = 0;
        dmemWait = 0;
    endtask

    task automatic test_halt();
        fillMem(32'h0000_0000);
        doReset();
        applyStimulus(2);
        total++;
        if (halted !== 1'b0) begin
            bad++;
            $display("[TB] FAIL halt_in_decode got=%0b want=0", halted);
        end
        applyStimulus(1);
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("[TB] FAIL halt_after_decode got=%0b want=1", halted);
        end
        applyStimulus(50);
        total++;
        if (imemReqCycles !== 0 || retireCycles.size() != 0) begin
            bad++;
            $display("[TB] FAIL halt_quiet got=req %0d retire %0d want=0 0",
                     imemReqCycles, retireCycles.size());
        end
        total++;
        if (halted !== 1'b1 || pc_out !== 64'h0) begin
            bad++;
            $display("[TB] FAIL halt_sticky got=halted %0b pc %0h want=1 0", halted, pc_out);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [63:0] gotA;
        fillMem(encB(26'd0));
        imem[0] = encD(11'h7C0, 5'd31, 5'd31, 9'd16);
        dmem[2] = 64'hBEEF;
        dmemWait = 1000;
        doReset();
        applyStimulus(5);
        total++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_store_pending got=req %0b we %0b want=1 1", dmem_req, dmem_we);
        end
        reset = 1'b1;
        #1;
        total++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("[TB] FAIL mid_store_req_drop got=dreq %0b ireq %0b want=0 0", dmem_req, imem_req);
        end
        repeat (2) @(negedge clk);
        total++;
        if (storeQ.size() != 0 || dmem[2] !== 64'hBEEF) begin
            bad++;
            $display("[TB] FAIL mid_store_no_write got=stores %0d mem %0h want=0 beef",
                     storeQ.size(), dmem[2]);
        end
        dmemWait = 0;
        reset = 1'b0;
        applyStimulus(8);
        gotA = (fetchAddrs.size() > 0) ? fetchAddrs[0] : 64'hFFFF_FFFF;
        total++;
        if (gotA !== 64'h0) begin
            bad++;
            $display("[TB] FAIL mid_store_restart got=%0h want=0", gotA);
        end
        total++;
        if (storeQ.size() != 1) begin
            bad++;
            $display("[TB] FAIL mid_store_rerun got=%0d want=1", storeQ.size());
        end
    endtask

    initial begin
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        dmem_ready = 1'b0;
        dmem_rdata = 64'h0;
        fillMem(encB(26'd0));
        $display("[TB] start");
        test_load_add_store();
        test_reset();
        test_alu_ops();
        test_branches();
        test_wait_states();
        test_halt();
        test_reset_mid_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
